datapath_mc: RTL and testbench
==============================

Name: datapath_mc

Overview:
- Multicycle successor of the single-cycle datapath: register file, extended ALU, compare flags and a handshaked data-memory port, sequenced by an internal FSM.
- Sits between the controller, which issues one operation per start pulse, and the data memory/cache, which may stall via mem_ready.
- Generalised in word width, register count and ALU op set.
- Fixes the single-cycle weaknesses:
  - flags come from a dedicated subtractor;
  - register write is gated by reg_write;
  - byte address is checked for word alignment.

Parameters:
NBITS, 32, datapath word width (>=8, power of two)
NREGS, 32, register count (power of two, >=2); register 0 is hardwired zero
WIDTH_ALUF, 4, ALU control width

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  controller requests an operation; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in WB cycle
rs1, rs2, rd  in  $clog2(NREGS)  register indices, latched at start
imm  in  NBITS  signed immediate, latched at start
alu_op  in  WIDTH_ALUF  ALU operation, latched at start
alu_src  in  1  1: SrcB=imm, 0: SrcB=reg[rs2]
mem_read, mem_write  in  1  load/store request (mutually exclusive)
reg_write  in  1  enables write of rd in WB
link  in  1  write pclink to rd instead of ALU/memory result
pclink  in  NBITS  PC value for link
pc_reg  out  NBITS  latched SrcA, returned to controller for jumps
zero, neg, carry  out  1  compare flags, registered at end of EXEC
mem_addr  out  NBITS-2  word address = alu_result[NBITS-1:2]
mem_wdata  out  NBITS  latched reg[rs2]
mem_rdata  in  NBITS  load data, valid with mem_ready
mem_req, mem_we  out  1  memory request / write qualifier
mem_ready  in  1  memory completes request this cycle
misaligned  out  1  high with done when a memory op had alu_result[1:0]!=0

Behaviour:
- Reset (asynchronous, active-low):
  - every register cleared, FSM to IDLE;
  - all outputs 0, including flags, mem_req and done;
  - reset during MEM drops mem_req immediately.
- FSM states: IDLE, EXEC, MEM, MUL (optional), WB.
- IDLE:
  - start=1: latch SrcA=reg[rs1] and SrcB (per alu_src), mem_wdata=reg[rs2], plus all control inputs; go to EXEC.
  - start while busy is ignored.
- EXEC (1 cycle):
  - register alu_result and flags;
  - next state MEM if mem_read|mem_write with aligned address, MUL if op is MUL, else WB.
- Misaligned memory op: skip MEM, go to WB with misaligned=1; no memory access and no register write.
- MEM:
  - mem_req=1; mem_we=mem_write; mem_addr and mem_wdata held stable;
  - stay until mem_ready=1, then latch mem_rdata (loads) and go to WB;
  - no timeout.
- WB (1 cycle):
  - done=1;
  - if reg_write and rd!=0, write reg[rd] at the end of the cycle;
  - write-data priority: link > mem_read > alu_result;
  - return to IDLE.
- Latency: ALU op: start at edge T, done high in cycle T+2. Load/store: T+2+wait cycles until mem_ready.
- Hazards: the next start is accepted only after WB, so back-to-back ops see updated registers.
- ALU ops:
  - ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101, MUL 1010.
  - Undefined codes act as ADD.
  - Shift amount is SrcB[$clog2(NBITS)-1:0].
  - All results wrap modulo 2^NBITS.
- Flags (from SrcA-SrcB, regardless of alu_op):
  - zero = equal;
  - neg = signed SrcA<SrcB (N xor V);
  - carry = unsigned SrcA>=SrcB (no borrow).
- reg[0] always reads 0 and is never written.

Optional Feature:
- DATAPATH_MUL_EN defined:
  - MUL routes EXEC to the MUL state, an iterative shift-add of NBITS cycles;
  - low NBITS of the product go to WB.
- Undefined: MUL state and hardware absent; MUL decodes as ADD with no extra cycles.

Decomposition:
- Package datapath_pkg holds:
  - alu_op_t enum with the codes above;
  - state_t enum;
  - the SUB/MUL constants shared with the controller.
- One sub-module, alu_mc: combinational ALU plus flag subtractor.
- The multiplier stays inside datapath_mc under the macro.

Test Plan:
- Reset mid-MEM (mem_ready held 0, reset low) -> mem_req=0 asynchronously, busy=0, all registers read 0 afterwards.
- ADDI r1=r0+5, then SUB r2=r1-r1 -> r1=5, r2=0, zero=1, carry=1, neg=0, done at T+2 each.
- SLT with r3=-1, r4=1 -> result 1, neg=1; SLTU -> result 0, carry=1.
- Store r1 to byte 8 with mem_ready delayed 3 cycles -> mem_addr=2, mem_we=1 held 3 cycles; load back into r5 -> r5=5.
- Load from byte address 6 -> misaligned=1 with done, mem_req never asserted, rd unchanged.
- DATAPATH_MUL_EN: 7*6 -> 42 after NBITS MUL cycles; rd=0 write attempt -> reg[0] stays 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared ALU op codes, FSM states and controller constants for datapath_mc
package datapath_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_MUL  = 4'b1010,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_MUL,
    S_WB
  } state_t;

  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1010;

endpackage

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - combinational ALU with a dedicated SrcA-SrcB subtractor for compare flags
module alu_mc
  import datapath_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input  logic [NBITS-1:0]      i_src_a,
  input  logic [NBITS-1:0]      i_src_b,
  input  logic [WIDTH_ALUF-1:0] i_alu_op,
  output logic [NBITS-1:0]      o_result,
  output logic                  o_zero,
  output logic                  o_neg,
  output logic                  o_carry
);

  localparam int SHW = $clog2(NBITS);

  logic [NBITS:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [3:0]       w_op;
  logic             w_ovf;

  assign w_op    = i_alu_op[3:0];
  assign w_shamt = i_src_b[SHW-1:0];

  // Carry out of a + ~b + 1 is the "no borrow" bit, i.e. unsigned a >= b.
  assign w_diff  = {1'b0, i_src_a} + {1'b0, ~i_src_b} + {{NBITS{1'b0}}, 1'b1};
  assign w_ovf   = (i_src_a[NBITS-1] ^ i_src_b[NBITS-1]) & (w_diff[NBITS-1] ^ i_src_a[NBITS-1]);
  assign o_carry = w_diff[NBITS];
  assign o_zero  = (w_diff[NBITS-1:0] == '0);
  assign o_neg   = w_diff[NBITS-1] ^ w_ovf;

  always_comb begin
    o_result = i_src_a + i_src_b;
    case (w_op)
      ALU_SLL:  o_result = i_src_a << w_shamt;
      ALU_SLT:  o_result = {{(NBITS-1){1'b0}}, o_neg};
      ALU_SLTU: o_result = {{(NBITS-1){1'b0}}, ~o_carry};
      ALU_XOR:  o_result = i_src_a ^ i_src_b;
      ALU_SRL:  o_result = i_src_a >> w_shamt;
      ALU_OR:   o_result = i_src_a | i_src_b;
      ALU_AND:  o_result = i_src_a & i_src_b;
      ALU_SUB:  o_result = w_diff[NBITS-1:0];
      ALU_SRA:  o_result = NBITS'($signed(i_src_a) >>> w_shamt);
      default:  o_result = i_src_a + i_src_b;
    endcase
  end

endmodule

// File: rtl/datapath_mc.sv
// rtl/datapath_mc.sv - multicycle datapath: regfile, ALU, flags, handshaked memory port
// Optional iterative multiplier enabled by defining DATAPATH_MUL_EN.
module datapath_mc
  import datapath_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [NBITS-1:0]         imm,
  input  logic [WIDTH_ALUF-1:0]    alu_op,
  input  logic                     alu_src,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic                     reg_write,
  input  logic                     link,
  input  logic [NBITS-1:0]         pclink,
  output logic [NBITS-1:0]         pc_reg,
  output logic                     zero,
  output logic                     neg,
  output logic                     carry,
  output logic [NBITS-3:0]         mem_addr,
  output logic [NBITS-1:0]         mem_wdata,
  input  logic [NBITS-1:0]         mem_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic                     misaligned
);

  localparam int RW  = $clog2(NREGS);

  state_t                r_state;
  logic [NBITS-1:0]      r_regs [NREGS];
  logic [NBITS-1:0]      r_src_a, r_src_b, r_wdata, r_pclink, r_alu_result, r_rdata;
  logic [RW-1:0]         r_rd;
  logic [WIDTH_ALUF-1:0] r_alu_op;
  logic                  r_mem_read, r_mem_write, r_reg_write, r_link;
  logic                  r_zero, r_neg, r_carry;
  logic                  r_busy, r_done, r_mem_req, r_mem_we, r_misaligned;

  logic [NBITS-1:0]      w_rs1_val, w_rs2_val, w_alu_res, w_wb_data;
  logic                  w_zero, w_neg, w_carry, w_is_mem, w_misal;

`ifdef DATAPATH_MUL_EN
  localparam int SHW = $clog2(NBITS);
  logic [NBITS-1:0]      r_mul_acc, r_mul_mcand, r_mul_mplier;
  logic [SHW-1:0]        r_mul_cnt;
  logic [NBITS-1:0]      w_mul_next;
  assign w_mul_next = r_mul_acc + (r_mul_mplier[0] ? r_mul_mcand : '0);
`endif

  assign w_rs1_val = (rs1 == '0) ? '0 : r_regs[rs1];
  assign w_rs2_val = (rs2 == '0) ? '0 : r_regs[rs2];
  assign w_is_mem  = r_mem_read | r_mem_write;
  assign w_misal   = (w_alu_res[1:0] != 2'b00);
  assign w_wb_data = r_link ? r_pclink : (r_mem_read ? r_rdata : r_alu_result);

  alu_mc #(.NBITS(NBITS), .WIDTH_ALUF(WIDTH_ALUF)) u_alu (
    .i_src_a  (r_src_a),
    .i_src_b  (r_src_b),
    .i_alu_op (r_alu_op),
    .o_result (w_alu_res),
    .o_zero   (w_zero),
    .o_neg    (w_neg),
    .o_carry  (w_carry)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_src_a      <= '0;
      r_src_b      <= '0;
      r_wdata      <= '0;
      r_pclink     <= '0;
      r_alu_result <= '0;
      r_rdata      <= '0;
      r_rd         <= '0;
      r_alu_op     <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_link       <= 1'b0;
      r_zero       <= 1'b0;
      r_neg        <= 1'b0;
      r_carry      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_misaligned <= 1'b0;
`ifdef DATAPATH_MUL_EN
      r_mul_acc    <= '0;
      r_mul_mcand  <= '0;
      r_mul_mplier <= '0;
      r_mul_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src_a     <= w_rs1_val;
            r_src_b     <= alu_src ? imm : w_rs2_val;
            r_wdata     <= w_rs2_val;
            r_rd        <= rd;
            r_alu_op    <= alu_op;
            r_mem_read  <= mem_read;
            r_mem_write <= mem_write;
            r_reg_write <= reg_write;
            r_link      <= link;
            r_pclink    <= pclink;
            r_busy      <= 1'b1;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_alu_result <= w_alu_res;
          r_zero       <= w_zero;
          r_neg        <= w_neg;
          r_carry      <= w_carry;
          if (w_is_mem && w_misal) begin
            r_misaligned <= 1'b1;
            r_done       <= 1'b1;
            r_state      <= S_WB;
          end else if (w_is_mem) begin
            r_mem_req <= 1'b1;
            r_mem_we  <= r_mem_write;
            r_state   <= S_MEM;
          end
`ifdef DATAPATH_MUL_EN
          else if (r_alu_op == WIDTH_ALUF'(OP_MUL)) begin
            r_mul_acc    <= '0;
            r_mul_mcand  <= r_src_a;
            r_mul_mplier <= r_src_b;
            r_mul_cnt    <= '0;
            r_state      <= S_MUL;
          end
`endif
          else begin
            r_done  <= 1'b1;
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_mem_read) r_rdata <= mem_rdata;
            r_done    <= 1'b1;
            r_state   <= S_WB;
          end
        end
`ifdef DATAPATH_MUL_EN
        // One partial product per cycle; the final sum lands directly in the result register.
        S_MUL: begin
          r_mul_acc    <= w_mul_next;
          r_mul_mcand  <= r_mul_mcand << 1;
          r_mul_mplier <= r_mul_mplier >> 1;
          r_mul_cnt    <= r_mul_cnt + 1'b1;
          if (r_mul_cnt == SHW'(NBITS-1)) begin
            r_alu_result <= w_mul_next;
            r_done       <= 1'b1;
            r_state      <= S_WB;
          end
        end
`endif
        S_WB: begin
          if (r_reg_write && (r_rd != '0) && !r_misaligned) r_regs[r_rd] <= w_wb_data;
          r_done       <= 1'b0;
          r_misaligned <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pc_reg     = r_src_a;
  assign zero       = r_zero;
  assign neg        = r_neg;
  assign carry      = r_carry;
  assign mem_addr   = r_alu_result[NBITS-1:2];
  assign mem_wdata  = r_wdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_datapath_mc.sv
// tb/tb_datapath_mc.sv - directed scoreboard bench for datapath_mc
module tb_datapath_mc;
  import datapath_pkg::*;

  localparam int NBITS = 32, NREGS = 32, WIDTH_ALUF = 4;

  logic        clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic        busy, done, zero, neg, carry, mem_req, mem_we, misaligned;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] imm = '0, pclink = '0, pc_reg, mem_wdata, mem_rdata = '0;
  logic [3:0]  alu_op = '0;
  logic        alu_src = 1'b0, mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, link = 1'b0;
  logic        mem_ready = 1'b0;
  logic [29:0] mem_addr;

  datapath_mc #(.NBITS(NBITS), .NREGS(NREGS), .WIDTH_ALUF(WIDTH_ALUF)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op), .alu_src(alu_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .link(link),
    .pclink(pclink), .pc_reg(pc_reg), .zero(zero), .neg(neg), .carry(carry),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          lat;
    logic        z, n, c, mis;
    logic [31:0] pc;
    int          reqs;
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [NREGS];
  logic [31:0] mem [16];
  int          n_total = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_total++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic run_op(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                        input logic [31:0] im, input logic [3:0] op, input logic src,
                        input logic mr, input logic mw, input logic rw, input logic lk,
                        input logic [31:0] pcl, input int wt, input logic [31:0] res);
    exp_t        e;
    logic [31:0] sa, sb, sum;
    int          cyc, reqs;
    bit          got;
    sa     = m_regs[a1];
    sb     = src ? im : m_regs[a2];
    sum    = sa + sb;
    e.z    = (sa == sb);
    e.n    = ($signed(sa) < $signed(sb));
    e.c    = (sa >= sb);
    e.mis  = (mr | mw) && (sum[1:0] != 2'b00);
    e.pc   = sa;
    e.addr = sum[31:2];
    e.we   = mw;
    e.wdata = m_regs[a2];
    e.reqs = ((mr | mw) && !e.mis) ? wt : 0;
    e.lat  = 2 + e.reqs;
`ifdef DATAPATH_MUL_EN
    if (op == OP_MUL && !(mr | mw)) e.lat = 2 + NBITS;
`endif
    exp_q.push_back(e);

    rs1 = a1; rs2 = a2; rd = d; imm = im; alu_op = op; alu_src = src;
    mem_read = mr; mem_write = mw; reg_write = rw; link = lk; pclink = pcl;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1; reqs = 0; got = 0;
    while (!got && cyc < 100) begin
      if (done) got = 1;
      else begin
        if (mem_req) begin
          reqs++;
          chk("mem_addr", {2'b00, mem_addr}, {2'b00, e.addr});
          chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          if (reqs >= wt) begin
            mem_ready = 1'b1;
            if (mem_we) mem[mem_addr[3:0]] = mem_wdata;
            mem_rdata = mem[mem_addr[3:0]];
          end
        end
        @(posedge clock); #1;
        mem_ready = 1'b0;
        cyc++;
      end
    end
    e = exp_q.pop_front();
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("latency", cyc, e.lat);
    chk("req_cycles", reqs, e.reqs);
    chk("pc_reg", pc_reg, e.pc);
    chk("flags_znc", {29'd0, zero, neg, carry}, {29'd0, e.z, e.n, e.c});
    chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
    if (rw && d != 5'd0 && !e.mis) m_regs[d] = res;
    @(posedge clock); #1;
    chk("idle_busy", {30'd0, busy, done}, 32'd0);
  endtask

  task automatic read_reg(input logic [4:0] x);
    run_op(x, 5'd0, 5'd0, 32'd0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    #12;
    chk("rst_ctrl", {26'd0, busy, done, mem_req, mem_we, misaligned, 1'b0}, 32'd0);
    chk("rst_flags", {29'd0, zero, neg, carry}, 32'd0);
    chk("rst_pc_reg", pc_reg, 32'd0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    @(posedge clock); #1 reset = 1'b1;

    // r1 = 5, then reset in the middle of a stalled store
    run_op(5'd0, 5'd0, 5'd1, 32'd5, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd5);
    read_reg(5'd1);
    rs1 = 5'd0; rs2 = 5'd1; imm = 32'd8; alu_op = ALU_ADD; alu_src = 1'b1;
    mem_write = 1'b1; reg_write = 1'b0; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(posedge clock); #1;
    chk("mid_mem_req", {31'd0, mem_req}, 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("rst_async_req", {31'd0, mem_req}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1; mem_write = 1'b0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    read_reg(5'd1);

    // ADDI / SUB
    run_op(5'd0, 5'd0, 5'd1, 32'd5, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd5);
    run_op(5'd1, 5'd1, 5'd2, 32'd0, ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd0);
    read_reg(5'd2);
    read_reg(5'd1);

    // SLT / SLTU with -1 and 1
    run_op(5'd0, 5'd0, 5'd3, 32'hFFFF_FFFF, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'hFFFF_FFFF);
    run_op(5'd0, 5'd0, 5'd4, 32'd1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd1);
    run_op(5'd3, 5'd4, 5'd6, 32'd0, ALU_SLT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd1);
    run_op(5'd3, 5'd4, 5'd7, 32'd0, ALU_SLTU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd0);
    read_reg(5'd6);
    read_reg(5'd7);

    // shifts, xor, link, reg_write gating
    run_op(5'd3, 5'd0, 5'd10, 32'd4, ALU_SRA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'hFFFF_FFFF);
    run_op(5'd4, 5'd0, 5'd11, 32'd31, ALU_SLL, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'h8000_0000);
    run_op(5'd1, 5'd0, 5'd15, 32'd3, ALU_XOR, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd6);
    run_op(5'd1, 5'd0, 5'd8, 32'd3, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 0, 32'h100);
    run_op(5'd1, 5'd0, 5'd9, 32'd3, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 32'd0);
    read_reg(5'd10);
    read_reg(5'd11);
    read_reg(5'd15);
    read_reg(5'd8);
    read_reg(5'd9);

    // store r1 to byte 8 with a 3-cycle stall, load it back into r5
    run_op(5'd0, 5'd1, 5'd0, 32'd8, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 3, 32'd0);
    run_op(5'd0, 5'd0, 5'd5, 32'd8, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1, 32'd5);
    read_reg(5'd5);

    // misaligned load: no memory access, r5 untouched
    run_op(5'd0, 5'd0, 5'd5, 32'd6, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1, 32'hDEAD_BEEF);
    read_reg(5'd5);

    // MUL 7*6 (decodes as ADD without the multiplier), and a write attempt to r0
    run_op(5'd0, 5'd0, 5'd12, 32'd7, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd7);
    run_op(5'd0, 5'd0, 5'd13, 32'd6, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd6);
`ifdef DATAPATH_MUL_EN
    run_op(5'd12, 5'd13, 5'd14, 32'd0, ALU_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd42);
`else
    run_op(5'd12, 5'd13, 5'd14, 32'd0, ALU_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd13);
`endif
    read_reg(5'd14);
    run_op(5'd12, 5'd13, 5'd0, 32'd0, ALU_MUL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'd42);
    read_reg(5'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
